ps2_mouse_rx: RTL and testbench
===============================

PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

Interface
REQ-001 CLK_FREQ, 25000000, slower_clk frequency in Hz.
REQ-002 TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside one frame or packet.
REQ-003 slower_clk  input  1  system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 ps2_clk  input  1  PS/2 clock line from mouse, asynchronous.
REQ-006 ps2_data  input  1  PS/2 data line from mouse, asynchronous.
REQ-007 enable  input  1  receive enable; low while host transmit owns the bus.
REQ-008 rx_byte  output  8  last accepted byte.
REQ-009 rx_byte_valid  output  1  one-cycle strobe per accepted byte.
REQ-010 x_move  output  9  signed X delta, two's complement.
REQ-011 y_move  output  9  signed Y delta, two's complement.
REQ-012 buttons  output  3  {middle, right, left}.
REQ-013 packet_valid  output  1  one-cycle strobe per complete 3-byte packet.
REQ-014 frame_error  output  1  one-cycle strobe on parity, start, stop, sync or timeout error.
REQ-015 busy  output  1  high while a frame is in progress.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is sync_prev=1 and sync_cur=0.
REQ-017 Each bit SHALL be sampled from synchronized ps2_data in the falling-edge cycle.
REQ-018 The frame FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
  - IDLE: leave on a falling edge when enable=1.
  - START: sampled bit must be 0, else error.
  - DATA: 8 bits, LSB first, counted 0..7.
  - PARITY: parity bit sampled.
  - STOP: stop bit sampled; return to IDLE.
REQ-019 Parity SHALL be odd: the 8 data bits plus the parity bit contain an odd number of ones; otherwise error.
REQ-020 Stop bit SHALL be 1; otherwise error.
REQ-021 On a good frame, rx_byte SHALL update and rx_byte_valid SHALL pulse one cycle after the stop-bit edge cycle.
REQ-022 A byte-index counter (0..2) SHALL assemble packets.
  - Index 0 byte with bit3=0: error, byte discarded, index stays 0 (resync).
REQ-023 On the index-2 byte:
  - x_move = {byte0[4], byte1}.
  - y_move = {byte0[5], byte2}.
  - buttons = byte0[2:0].
  - packet_valid pulses in the same cycle as that rx_byte_valid.
  - Index wraps to 0.
REQ-024 x_move, y_move and buttons SHALL hold until the next packet_valid.
REQ-025 Timeout (TIMEOUT_US*CLK_FREQ/1e6 cycles with no falling edge while busy=1 or index!=0): abort to IDLE, index=0, pulse frame_error.
REQ-026 Any error SHALL return the FSM to IDLE, set index=0, assert no rx_byte_valid, and pulse frame_error exactly once.
REQ-027 enable=0 SHALL force IDLE and index=0 within one cycle with no strobes; edges while enable=0 SHALL be ignored.
REQ-028 busy SHALL be high in START through STOP.

Reset
REQ-029 On reset low: FSM=IDLE, index=0, bit counter=0, timeout counter=0, synchronizers=1, all outputs 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no strobe.
REQ-031 The first frame is accepted only from a falling edge seen after reset release.

Structure
REQ-032 A shared package ps2_pkg SHALL hold the FSM state encoding, frame bit count (11), packet length (3), and byte0 field positions (sync bit 3, X sign 4, Y sign 5).
REQ-033 One sub-module, ps2_frame_rx, SHALL contain the synchronizer, edge detect, frame FSM and parity check, emitting byte/valid/error; the top level adds packet assembly and timeout.

Verification
REQ-034 Frame 0xFA with parity 1 and stop 1 -> rx_byte=0xFA, one rx_byte_valid, no packet_valid, index=1.
REQ-035 Packet 0x29 (parity 0), 0x05 (parity 1), 0xFE (parity 0) -> packet_valid once with x_move=0x005, y_move=0x1FE (-2), buttons=3'b001.
REQ-036 0x05 sent with parity 0 -> frame_error one cycle, no rx_byte_valid, index=0.
REQ-037 Byte0 0x01 (bit3=0) -> frame_error; a following valid 3-byte packet is then decoded correctly.
REQ-038 Clocking stops after 5 bits for >2 ms -> frame_error once, busy=0; the next full packet decodes.
REQ-039 reset pulsed after 4 bits, or enable dropped mid-packet -> no strobes; the next packet decodes from byte 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receiver: frame FSM encoding,
// frame/packet sizes and the byte0 field positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;
  localparam int PACKET_LEN = 3;

  localparam int SYNC_BIT   = 3;
  localparam int X_SIGN_BIT = 4;
  localparam int Y_SIGN_BIT = 5;

endpackage

// File: rtl/ps2_frame_rx.sv
// Single PS/2 frame receiver: synchronizes the bus, detects falling clock
// edges and checks start, odd parity and stop bits of each 11-bit frame.
module ps2_frame_rx
  import ps2_pkg::*;
(
  input  logic       slower_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       abort,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       byte_done,
  output logic       frame_err,
  output logic       busy,
  output logic       fall_edge
);

  frame_state_t state, next_state;

  logic       clk_meta, clk_sync, clk_prev;
  logic       data_meta, data_sync;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       start_bit;
  logic       parity_bit;

  assign fall_edge = clk_prev & ~clk_sync;
  assign busy      = (state != IDLE);
  assign data      = shift_reg;

  always_ff @(posedge slower_clk or negedge reset) begin
    if (!reset) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      clk_prev   <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      start_bit  <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
      state     <= next_state;
      if (state == IDLE)
        bit_cnt <= '0;
      if (fall_edge && enable) begin
        case (state)
          IDLE:   start_bit  <= data_sync;
          DATA: begin
            shift_reg <= {data_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          PARITY: parity_bit <= data_sync;
          default: ;
        endcase
      end
    end
  end

  // Stop-edge cycle decides the frame: odd parity over data+parity and stop=1
  always_comb begin
    next_state = state;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    if (!enable || abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:
          if (fall_edge) next_state = START;
        START:
          if (start_bit) begin
            next_state = IDLE;
            frame_err  = 1'b1;
          end else begin
            next_state = DATA;
          end
        DATA:
          if (fall_edge && bit_cnt == 3'(DATA_BITS - 1)) next_state = PARITY;
        PARITY:
          if (fall_edge) next_state = STOP;
        STOP:
          if (fall_edge) begin
            next_state = IDLE;
            if ((^{shift_reg, parity_bit}) && data_sync)
              byte_done = 1'b1;
            else
              frame_err = 1'b1;
          end
        default:
          next_state = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: assembles 3-byte movement packets from received
// frames and aborts stalled frames/packets after a timeout.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       slower_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       enable,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [8:0] x_move,
  output logic [8:0] y_move,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       frame_error,
  output logic       busy
);

  // Split the product so the default parameters do not overflow 32 bits
  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_US / 1000;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]      frame_data;
  logic            byte_done;
  logic            frame_err;
  logic            fall_edge;
  logic            timeout_hit;
  logic            timeout_active;
  logic [TO_W-1:0] timeout_cnt;
  logic [1:0]      byte_index;
  logic            x_sign, y_sign;
  logic [2:0]      btn_hold;
  logic [7:0]      byte1;

  assign timeout_active = enable && (busy || byte_index != 2'd0);
  assign timeout_hit    = timeout_active && !fall_edge &&
                          (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  ps2_frame_rx u_frame (
    .slower_clk (slower_clk),
    .reset      (reset),
    .enable     (enable),
    .abort      (timeout_hit),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (frame_data),
    .byte_done  (byte_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .fall_edge  (fall_edge)
  );

  always_ff @(posedge slower_clk or negedge reset) begin
    if (!reset)
      timeout_cnt <= '0;
    else if (!timeout_active || fall_edge || timeout_hit)
      timeout_cnt <= '0;
    else
      timeout_cnt <= timeout_cnt + 1'b1;
  end

  // Packet assembly; a byte0 without the sync bit is dropped to resync
  always_ff @(posedge slower_clk or negedge reset) begin
    if (!reset) begin
      byte_index    <= 2'd0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      packet_valid  <= 1'b0;
      frame_error   <= 1'b0;
      x_move        <= '0;
      y_move        <= '0;
      buttons       <= '0;
      x_sign        <= 1'b0;
      y_sign        <= 1'b0;
      btn_hold      <= '0;
      byte1         <= '0;
    end else begin
      rx_byte_valid <= 1'b0;
      packet_valid  <= 1'b0;
      frame_error   <= 1'b0;
      if (!enable) begin
        byte_index <= 2'd0;
      end else if (timeout_hit || frame_err) begin
        frame_error <= 1'b1;
        byte_index  <= 2'd0;
      end else if (byte_done) begin
        if (byte_index == 2'd0 && !frame_data[SYNC_BIT]) begin
          frame_error <= 1'b1;
        end else begin
          rx_byte       <= frame_data;
          rx_byte_valid <= 1'b1;
          if (byte_index == 2'd0) begin
            x_sign     <= frame_data[X_SIGN_BIT];
            y_sign     <= frame_data[Y_SIGN_BIT];
            btn_hold   <= frame_data[2:0];
            byte_index <= 2'd1;
          end else if (byte_index == 2'(PACKET_LEN - 2)) begin
            byte1      <= frame_data;
            byte_index <= 2'(PACKET_LEN - 1);
          end else begin
            x_move       <= {x_sign, byte1};
            y_move       <= {y_sign, frame_data};
            buttons      <= btn_hold;
            packet_valid <= 1'b1;
            byte_index   <= 2'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: frames, packets, error paths, timeout,
// mid-frame reset and enable drop, with hand-computed expected values.
module tb_ps2_mouse_rx;

  localparam int HALF = 10;

  logic       slower_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       enable     = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [8:0] x_move, y_move;
  logic [2:0] buttons;
  logic       packet_valid;
  logic       frame_error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int n_rx  = 0;
  int n_pkt = 0;
  int n_err = 0;
  logic [7:0] pkt_byte = '0;

  ps2_mouse_rx #(
    .CLK_FREQ   (1000000),
    .TIMEOUT_US (500)
  ) dut (
    .slower_clk    (slower_clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .enable        (enable),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .x_move        (x_move),
    .y_move        (y_move),
    .buttons       (buttons),
    .packet_valid  (packet_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 slower_clk = ~slower_clk;

  // Strobe counters sampled mid-cycle; each high cycle counts once
  always @(negedge slower_clk) begin
    if (rx_byte_valid) n_rx++;
    if (frame_error) n_err++;
    if (packet_valid) begin
      n_pkt++;
      pkt_byte = rx_byte;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge slower_clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_parity);
    logic p;
    p = ~(^d) ^ bad_parity;
    send_bits({1'b1, p, d, 1'b0}, 11);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    wait_cycles(5);
  endtask

  task automatic check_packet(input string name, input int pkt0, input int rx0, input int err0,
                              input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] eb);
    tests++;
    if (n_pkt - pkt0 !== 1) begin
      fails++;
      $display("[TB] FAIL %s_pkt_count: got %0d expected 1", name, n_pkt - pkt0);
    end
    tests++;
    if (n_rx - rx0 !== 3) begin
      fails++;
      $display("[TB] FAIL %s_rx_count: got %0d expected 3", name, n_rx - rx0);
    end
    tests++;
    if (n_err - err0 !== 0) begin
      fails++;
      $display("[TB] FAIL %s_err_count: got %0d expected 0", name, n_err - err0);
    end
    tests++;
    if ({x_move, y_move, buttons} !== {ex, ey, eb}) begin
      fails++;
      $display("[TB] FAIL %s_fields: got x=%h y=%h b=%b expected x=%h y=%h b=%b",
               name, x_move, y_move, buttons, ex, ey, eb);
    end
  endtask

  task automatic test_reset;
    wait_cycles(3);
    tests++;
    if ({rx_byte, rx_byte_valid, x_move, y_move, buttons, packet_valid, frame_error, busy} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got rx=%h x=%h y=%h b=%b busy=%b expected all zero",
               rx_byte, x_move, y_move, buttons, busy);
    end
    reset = 1'b1;
    wait_cycles(3);
    tests++;
    if (n_rx + n_pkt + n_err !== 0) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %0d expected 0", n_rx + n_pkt + n_err);
    end
  endtask

  task automatic test_single_byte;
    int rx0, pkt0, err0;
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_byte(8'hFA, 1'b0);
    wait_cycles(5);
    tests++;
    if (rx_byte !== 8'hFA) begin
      fails++;
      $display("[TB] FAIL single_rx_byte: got %h expected fa", rx_byte);
    end
    tests++;
    if ({n_rx - rx0, n_pkt - pkt0, n_err - err0} !== {32'd1, 32'd0, 32'd0}) begin
      fails++;
      $display("[TB] FAIL single_strobes: got rx=%0d pkt=%0d err=%0d expected 1 0 0",
               n_rx - rx0, n_pkt - pkt0, n_err - err0);
    end
    tests++;
    if (dut.byte_index !== 2'd1) begin
      fails++;
      $display("[TB] FAIL single_index: got %0d expected 1", dut.byte_index);
    end
    enable = 1'b0;
    wait_cycles(2);
    enable = 1'b1;
    tests++;
    if (dut.byte_index !== 2'd0) begin
      fails++;
      $display("[TB] FAIL single_index_clear: got %0d expected 0", dut.byte_index);
    end
  endtask

  task automatic test_packet;
    int rx0, pkt0, err0;
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_packet(8'h29, 8'h05, 8'hFE);
    check_packet("packet", pkt0, rx0, err0, 9'h005, 9'h1FE, 3'b001);
    tests++;
    if (pkt_byte !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL packet_same_cycle_byte: got %h expected fe", pkt_byte);
    end
  endtask

  task automatic test_parity_error;
    int rx0, err0;
    rx0 = n_rx; err0 = n_err;
    send_byte(8'h05, 1'b1);
    wait_cycles(5);
    tests++;
    if (n_err - err0 !== 1) begin
      fails++;
      $display("[TB] FAIL parity_err_count: got %0d expected 1", n_err - err0);
    end
    tests++;
    if (n_rx - rx0 !== 0) begin
      fails++;
      $display("[TB] FAIL parity_rx_count: got %0d expected 0", n_rx - rx0);
    end
    tests++;
    if (dut.byte_index !== 2'd0) begin
      fails++;
      $display("[TB] FAIL parity_index: got %0d expected 0", dut.byte_index);
    end
  endtask

  task automatic test_sync_error;
    int rx0, pkt0, err0;
    rx0 = n_rx; err0 = n_err;
    send_byte(8'h01, 1'b0);
    wait_cycles(5);
    tests++;
    if ({n_err - err0, n_rx - rx0} !== {32'd1, 32'd0}) begin
      fails++;
      $display("[TB] FAIL sync_err: got err=%0d rx=%0d expected 1 0", n_err - err0, n_rx - rx0);
    end
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_packet(8'h18, 8'h10, 8'h20);
    check_packet("sync_resync", pkt0, rx0, err0, 9'h110, 9'h020, 3'b000);
  endtask

  task automatic test_timeout;
    int rx0, pkt0, err0;
    err0 = n_err;
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_busy_mid: got %b expected 1", busy);
    end
    wait_cycles(600);
    tests++;
    if (n_err - err0 !== 1) begin
      fails++;
      $display("[TB] FAIL timeout_err_count: got %0d expected 1", n_err - err0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_busy_after: got %b expected 0", busy);
    end
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_packet(8'h3F, 8'hFF, 8'h01);
    check_packet("timeout_recover", pkt0, rx0, err0, 9'h1FF, 9'h101, 3'b111);
  endtask

  task automatic test_reset_mid_frame;
    int rx0, pkt0, err0;
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 4);
    reset = 1'b0;
    wait_cycles(3);
    tests++;
    if (x_move !== 9'h000) begin
      fails++;
      $display("[TB] FAIL reset_mid_xmove: got %h expected 000", x_move);
    end
    reset = 1'b1;
    wait_cycles(3);
    tests++;
    if ({n_rx - rx0, n_pkt - pkt0, n_err - err0, 31'd0, busy} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_strobes: got rx=%0d pkt=%0d err=%0d busy=%b expected none",
               n_rx - rx0, n_pkt - pkt0, n_err - err0, busy);
    end
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_packet(8'h29, 8'h05, 8'hFE);
    check_packet("reset_recover", pkt0, rx0, err0, 9'h005, 9'h1FE, 3'b001);
  endtask

  task automatic test_enable_drop;
    int rx0, pkt0, err0;
    send_byte(8'h29, 1'b0);
    send_byte(8'h05, 1'b0);
    pkt0 = n_pkt; err0 = n_err;
    enable = 1'b0;
    wait_cycles(3);
    tests++;
    if (dut.byte_index !== 2'd0) begin
      fails++;
      $display("[TB] FAIL enable_index: got %0d expected 0", dut.byte_index);
    end
    tests++;
    if ({n_pkt - pkt0, n_err - err0} !== '0) begin
      fails++;
      $display("[TB] FAIL enable_strobes: got pkt=%0d err=%0d expected 0 0", n_pkt - pkt0, n_err - err0);
    end
    enable = 1'b1;
    wait_cycles(3);
    rx0 = n_rx; pkt0 = n_pkt; err0 = n_err;
    send_packet(8'h18, 8'h10, 8'h20);
    check_packet("enable_recover", pkt0, rx0, err0, 9'h110, 9'h020, 3'b000);
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_packet;
    test_parity_error;
    test_sync_error;
    test_timeout;
    test_reset_mid_frame;
    test_enable_drop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
